// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-256 encryption round controller.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, INIT, RND, FIN, DONE} ctrl_state_t;

    typedef enum logic [1:0] {PH_SB, PH_SR, PH_MC, PH_ARK} phase_t;

    localparam int unsigned AES256_NR = 14;

    function automatic int unsigned LATENCY(input int unsigned nr);
        return 4 * nr + 1;
    endfunction

endpackage

// File: rtl/mod_enc_round_ctrl.sv
// AES-256 encryption round sequencer: stage write enables, round-key index, block handshakes.
// Optional key-ready stall on every AddRoundKey cycle: MOD_ENC_ROUND_CTRL_KEY_STALL_EN.
module mod_enc_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NR     = AES256_NR,
    parameter int unsigned KIDX_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef MOD_ENC_ROUND_CTRL_KEY_STALL_EN
    input  logic              key_rdy,
`endif
    output logic              sb_wr_en,
    output logic              sr_wr_en,
    output logic              mc_wr_en,
    output logic              ark_wr_en,
    output logic              in_sel,
    output logic              mc_bypass,
    output logic [KIDX_W-1:0] key_idx,
    output logic [KIDX_W-1:0] round,
    output logic              busy
);

    ctrl_state_t       state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [KIDX_W-1:0] round_q, round_d;
    logic              key_ok;

    logic              sb_d, sr_d, mc_d, ark_d, in_sel_d, mc_bypass_d, out_valid_d, busy_d;
    logic [KIDX_W-1:0] key_idx_d;
    logic              sb_q, sr_q, mc_q, ark_q, in_sel_q, mc_bypass_q, out_valid_q, busy_q;
    logic [KIDX_W-1:0] key_idx_q;

`ifdef MOD_ENC_ROUND_CTRL_KEY_STALL_EN
    assign key_ok = key_rdy;
`else
    assign key_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            phase_q     <= PH_SB;
            round_q     <= '0;
            sb_q        <= 1'b0;
            sr_q        <= 1'b0;
            mc_q        <= 1'b0;
            ark_q       <= 1'b0;
            in_sel_q    <= 1'b0;
            mc_bypass_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            key_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            round_q     <= round_d;
            sb_q        <= sb_d;
            sr_q        <= sr_d;
            mc_q        <= mc_d;
            ark_q       <= ark_d;
            in_sel_q    <= in_sel_d;
            mc_bypass_q <= mc_bypass_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            key_idx_q   <= key_idx_d;
        end
    end

    // A stalled ARK (key_ok low) simply holds state, so every registered output stays frozen.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = INIT;
                    phase_d = PH_SB;
                    round_d = '0;
                end
            end
            INIT: begin
                if (key_ok) begin
                    state_d = RND;
                    phase_d = PH_SB;
                    round_d = KIDX_W'(1);
                end
            end
            RND: begin
                if (phase_q == PH_ARK) begin
                    if (key_ok) begin
                        phase_d = PH_SB;
                        if (round_q == KIDX_W'(NR - 1)) begin
                            state_d = FIN;
                            round_d = KIDX_W'(NR);
                        end else begin
                            round_d = round_q + KIDX_W'(1);
                        end
                    end
                end else begin
                    phase_d = phase_t'(phase_q + 2'd1);
                end
            end
            FIN: begin
                // Final round walks SB -> SR -> ARK, skipping the MixColumns phase.
                case (phase_q)
                    PH_SB:   phase_d = PH_SR;
                    PH_SR:   phase_d = PH_ARK;
                    default: begin
                        if (key_ok) begin
                            state_d = DONE;
                            phase_d = PH_SB;
                        end
                    end
                endcase
            end
            DONE: begin
                if (out_ready) begin
                    phase_d = PH_SB;
                    round_d = '0;
                    state_d = in_valid ? INIT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = PH_SB;
                round_d = '0;
            end
        endcase
    end

    always_comb begin
        sb_d        = (state_d == RND || state_d == FIN) && phase_d == PH_SB;
        sr_d        = (state_d == RND || state_d == FIN) && phase_d == PH_SR;
        mc_d        = (state_d == RND) && phase_d == PH_MC;
        ark_d       = (state_d == INIT) ||
                      ((state_d == RND || state_d == FIN) && phase_d == PH_ARK);
        in_sel_d    = (state_d == INIT);
        mc_bypass_d = (state_d == FIN) && phase_d == PH_ARK;
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        key_idx_d   = '0;
        if (ark_d && state_d != INIT)
            key_idx_d = round_d;
    end

    assign sb_wr_en  = sb_q;
    assign sr_wr_en  = sr_q;
    assign mc_wr_en  = mc_q;
    assign ark_wr_en = ark_q && key_ok;
    assign in_sel    = in_sel_q;
    assign mc_bypass = mc_bypass_q;
    assign key_idx   = key_idx_q;
    assign round     = round_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);

endmodule

// File: tb/tb_mod_enc_round_ctrl.sv
// Directed bench for mod_enc_round_ctrl; exercises the key-stall path when
// MOD_ENC_ROUND_CTRL_KEY_STALL_EN is defined.
module tb_mod_enc_round_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en, in_sel, mc_bypass, busy;
    logic [3:0] key_idx, round;
`ifdef MOD_ENC_ROUND_CTRL_KEY_STALL_EN
    logic       key_rdy = 1'b1;
`endif

    int tests  = 0;
    int failed = 0;
    int cyc;
    int mc_cnt, ark_cnt, ark_bad, hot_bad, stall_at;

    mod_enc_round_ctrl #(.NR(14), .KIDX_W(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MOD_ENC_ROUND_CTRL_KEY_STALL_EN
        .key_rdy   (key_rdy),
`endif
        .sb_wr_en  (sb_wr_en),
        .sr_wr_en  (sr_wr_en),
        .mc_wr_en  (mc_wr_en),
        .ark_wr_en (ark_wr_en),
        .in_sel    (in_sel),
        .mc_bypass (mc_bypass),
        .key_idx   (key_idx),
        .round     (round),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the accepting edge (cycle 1); returns the cycle in which out_valid is seen.
    task automatic wait_done(output int c);
        int en_sum;
        mc_cnt = 0; ark_cnt = 0; ark_bad = 0; hot_bad = 0;
        c = 1;
        forever begin
`ifdef MOD_ENC_ROUND_CTRL_KEY_STALL_EN
            if (c == stall_at)     key_rdy = 1'b0;
            if (c == stall_at + 3) key_rdy = 1'b1;
`endif
            #1;
            if (out_valid || c >= 200) break;
            en_sum = int'(sb_wr_en) + int'(sr_wr_en) + int'(mc_wr_en) + int'(ark_wr_en);
`ifdef MOD_ENC_ROUND_CTRL_KEY_STALL_EN
            if (!key_rdy && en_sum != 0) hot_bad++;
            if (key_rdy && en_sum != 1) hot_bad++;
`else
            if (en_sum != 1) hot_bad++;
`endif
            if (mc_wr_en) mc_cnt++;
            if (mc_wr_en && mc_bypass) hot_bad++;
            if (ark_wr_en) begin
                if (key_idx != 4'(ark_cnt)) ark_bad++;
                if (mc_bypass != (ark_cnt == 14)) ark_bad++;
                ark_cnt++;
            end else if (mc_bypass) begin
                ark_bad++;
            end
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall_at  = -10;
        #2;
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_enables",   32'({sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en, in_sel, mc_bypass}), 0);
        chk("rst_round_kidx", 32'({round, key_idx}), 0);
        tick; tick;
        resetn = 1'b1;
        tick;

        // Single block with the consumer always ready.
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("init_ark",    32'(ark_wr_en), 1);
        chk("init_in_sel", 32'(in_sel),    1);
        chk("init_rdy",    32'(in_ready),  0);
        chk("init_round",  32'(round),     0);
        wait_done(cyc);
        chk("lat_single",  32'(cyc),      57);
        chk("mc_pulses",   32'(mc_cnt),   13);
        chk("ark_count",   32'(ark_cnt),  15);
        chk("ark_keyseq",  32'(ark_bad),  0);
        chk("one_hot",     32'(hot_bad),  0);
        chk("done_round",  32'(round),    14);
        chk("done_rdy",    32'(in_ready), 1);
        tick;
        chk("idle_after_done", 32'({busy, out_valid}), 0);

        // Final-round shape, sampled cycle by cycle.
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (53) tick;
        chk("fin_sb",     32'({sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en, mc_bypass}), 5'b10000);
        chk("fin_round",  32'(round), 14);
        tick;
        chk("fin_sr",     32'({sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en, mc_bypass}), 5'b01000);
        tick;
        chk("fin_ark",    32'({sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en, mc_bypass}), 5'b00011);
        chk("fin_kidx",   32'(key_idx), 14);
        tick;
        chk("fin_done",   32'(out_valid), 1);
        tick;

        // Backpressure: result held for 10 cycles, a second block is ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_done(cyc);
        chk("lat_bp", 32'(cyc), 57);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_hold", 32'({out_valid, round, in_ready, busy}), {1'b1, 4'd14, 1'b0, 1'b1});
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("bp_release_idle", 32'({busy, out_valid, in_ready}), 3'b001);

        // Back-to-back: accept a new block in the DONE cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_done(cyc);
        tick;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        chk("b2b_init", 32'({out_valid, ark_wr_en, in_sel, busy}), 4'b0111);
        wait_done(cyc);
        chk("lat_b2b", 32'(cyc), 57);
        tick;

        // Reset in round 7, phase 2 (cycle 28 after acceptance).
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (27) tick;
        chk("r7_mc", 32'({mc_wr_en, round}), {1'b1, 4'd7});
        resetn = 1'b0;
        #1;
        chk("arst_enables", 32'({sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en, busy, out_valid}), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        tick;
        resetn   = 1'b1;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_done(cyc);
        chk("lat_after_rst", 32'(cyc), 57);
        tick;

`ifdef MOD_ENC_ROUND_CTRL_KEY_STALL_EN
        // Round 5 ARK falls in cycle 21; hold key_rdy low for three cycles there.
        stall_at = 21;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_done(cyc);
        chk("lat_stall",   32'(cyc), 60);
        chk("stall_keys",  32'(ark_bad), 0);
        chk("stall_hot",   32'(hot_bad), 0);
        stall_at = -10;
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mod_enc_round_ctrl.md
Name: mod_enc_round_ctrl

Overview:
- Sequences one AES-256 encryption through the round datapath: initial AddRoundKey, 13 full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey), then a final round that skips MixColumns.
- Generates the per-stage write enables (including mixColumns wr_en), the round-key index and the block-level valid/ready handshakes.
- Sits between the encryption top-level I/O and the stage modules; it owns no state data, only control.

Parameters:
- NR, 14, number of rounds (AES-256); key_idx runs 0..NR.
- KIDX_W, 4, width of key_idx; must satisfy 2**KIDX_W > NR.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext block present on datapath input.
- in_ready  out  1  controller can accept a block.
- out_valid  out  1  ciphertext stable at datapath output.
- out_ready  in  1  consumer takes ciphertext.
- sb_wr_en  out  1  SubBytes stage load.
- sr_wr_en  out  1  ShiftRows stage load.
- mc_wr_en  out  1  mixColumns stage wr_en.
- ark_wr_en  out  1  AddRoundKey stage load.
- in_sel  out  1  1 = AddRoundKey takes the input block; 0 = takes the round result.
- mc_bypass  out  1  1 = AddRoundKey takes the ShiftRows output (final round).
- key_idx  out  KIDX_W  round key number for the current ARK.
- round  out  KIDX_W  current round, 0 = initial ARK.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low): state IDLE. All outputs 0 except in_ready = 1. Reset asserted mid-operation aborts the block immediately; no out_valid is produced for it.
- States:
  - IDLE: in_ready = 1. On in_valid, go to INIT.
  - INIT: 1 cycle. ark_wr_en = 1, in_sel = 1, key_idx = 0, round = 0. Go to RND with round = 1, phase = 0.
  - RND: rounds 1..NR-1. Phase counter (2 bits) cycles 0 -> sb_wr_en, 1 -> sr_wr_en, 2 -> mc_wr_en, 3 -> ark_wr_en with key_idx = round. At phase 3: if round == NR-1, go to FIN with round = NR; otherwise round increments.
  - FIN: phase 0 sb_wr_en, 1 sr_wr_en, 2 ark_wr_en with mc_bypass = 1 and key_idx = NR. mc_wr_en is never asserted in FIN. Then go to DONE.
  - DONE: out_valid = 1, held with round = NR until out_ready. in_ready = out_ready in DONE.
    - out_ready && in_valid: go to INIT directly; the new block is accepted in the same cycle.
    - out_ready && !in_valid: go to IDLE.
- Exactly one stage write enable is high per cycle in INIT, RND and FIN; none in IDLE or DONE.
- Latency: out_valid rises exactly 4*NR+1 cycles after the accepting edge (57 for NR = 14). Throughput is one block per 4*NR+1 cycles plus any backpressure.
- Handshake rules:
  - in_valid while busy (other than DONE with out_ready) is ignored and in_ready = 0.
  - out_valid, once high, stays high until the edge where out_ready is seen.
- All outputs are registered (Moore).

Optional Feature:
- Macro: MOD_ENC_ROUND_CTRL_KEY_STALL_EN.
- Defined: adds input key_rdy (1 bit). Every ARK cycle (INIT, RND phase 3, FIN phase 2) holds ark_wr_en low and all outputs frozen until key_rdy = 1. The ARK completes on the first cycle key_rdy is high. Latency becomes 4*NR+1 plus the stall cycles.
- Undefined: no key_rdy port; ARK always completes in one cycle.

Decomposition:
- Package aes_ctrl_pkg:
  - ctrl_state_t enum {IDLE, INIT, RND, FIN, DONE}.
  - phase_t enum {PH_SB, PH_SR, PH_MC, PH_ARK}.
  - AES256_NR = 14.
  - LATENCY function returning 4*NR+1.
- No sub-module: a single FSM with phase and round counters. It is to be instantiated beside the stage modules in the encryption top.

Test Plan:
- Single block, out_ready = 1: in_valid pulse at cycle 0 -> out_valid at cycle 57; key_idx sequence on ARK cycles 0, 1..14; exactly 13 mc_wr_en pulses.
- Final-round check: during FIN, mc_wr_en = 0 throughout, mc_bypass = 1 only on the ARK cycle, key_idx = 14.
- Backpressure: out_ready = 0 for 10 cycles after out_valid -> out_valid, round = 14 held; in_ready = 0; a second in_valid is ignored.
- Back-to-back: in_valid and out_ready both high in DONE -> same-cycle accept, INIT next cycle, second out_valid exactly 57 cycles later.
- Reset mid-operation: resetn low during round 7 phase 2 -> all enables 0 and busy = 0 asynchronously, in_ready = 1; a new block completes in 57 cycles.
- Macro defined: key_rdy low for 3 cycles at round 5 ARK -> outputs frozen 3 cycles, out_valid at cycle 60.
